// File: rtl/beam_mux_pkg.sv
// Shared types and constants for the beam source-to-DAC burst multiplexer.
// Holds the FSM state encoding and the saturating drop-counter helper.
package beam_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_DROP  = 2'd2
   } mux_state_e;

   localparam int unsigned DROP_CNT_W = 16;

   function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + DROP_CNT_W'(1);
   endfunction

endpackage

// File: rtl/beam_mux_out_stage.sv
// Single-entry output register shared by all DAC channels.
// Data is broadcast to every slice; only the latched channel sees tvalid.
module beam_mux_out_stage #(
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned NUM_DAC = 4,
   localparam int unsigned SEL_W   = $clog2(NUM_DAC)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic [DATA_W-1:0]         load_data,
   input  logic                      load_last,
   input  logic [SEL_W-1:0]          load_chan,
   input  logic [NUM_DAC-1:0]        dac_tready,
   output logic                      full,
   output logic                      room,
   output logic [NUM_DAC*DATA_W-1:0] dac_tdata,
   output logic [NUM_DAC-1:0]        dac_tvalid,
   output logic [NUM_DAC-1:0]        dac_tlast
);

   logic [DATA_W-1:0] data_q;
   logic              last_q;
   logic [SEL_W-1:0]  chan_q;
   logic              full_q;
   logic              drain;

   assign drain = full_q && dac_tready[chan_q];
   assign room  = !full_q || dac_tready[chan_q];
   assign full  = full_q;

   // A load while draining overwrites in place, giving one beat per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         last_q <= 1'b0;
         chan_q <= '0;
         full_q <= 1'b0;
      end else if (load) begin
         data_q <= load_data;
         last_q <= load_last;
         chan_q <= load_chan;
         full_q <= 1'b1;
      end else if (drain) begin
         full_q <= 1'b0;
      end
   end

   always_comb begin
      dac_tvalid = '0;
      dac_tlast  = '0;
      for (int unsigned k = 0; k < NUM_DAC; k++) begin
         if (full_q && (chan_q == SEL_W'(k))) begin
            dac_tvalid[k] = 1'b1;
            dac_tlast[k]  = last_q;
         end
      end
   end

   assign dac_tdata = {NUM_DAC{data_q}};

endmodule

// File: rtl/beam_mux_gen2.sv
// Routes AXI-Stream bursts from one source to one of NUM_DAC outputs.
// Out-of-range channels are swallowed and counted; routed burst lengths are checked.
module beam_mux_gen2
   import beam_mux_pkg::*;
#(
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned NUM_DAC = 4,
   parameter  int unsigned LEN_W   = 16,
   localparam int unsigned SEL_W   = $clog2(NUM_DAC)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [DATA_W-1:0]         axis_source_tdata,
   input  logic                      axis_source_tvalid,
   output logic                      axis_source_tready,
   input  logic                      axis_source_tlast,
   input  logic [SEL_W-1:0]          i_dac_sel,
   input  logic [LEN_W-1:0]          i_burst_len,
   output logic [NUM_DAC*DATA_W-1:0] axis_dac_tdata,
   output logic [NUM_DAC-1:0]        axis_dac_tvalid,
   input  logic [NUM_DAC-1:0]        axis_dac_tready,
   output logic [NUM_DAC-1:0]        axis_dac_tlast,
   output logic                      o_burst_size_error,
   output logic [DROP_CNT_W-1:0]     o_drop_count,
   output logic                      o_busy
);

   mux_state_e            state_q;
   logic [SEL_W-1:0]      chan_q;
   logic [LEN_W-1:0]      beat_cnt_q;
   logic [LEN_W-1:0]      next_cnt;
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic                  err_q;
   logic                  ready_en_q;
   logic                  room;
   logic                  full;
   logic                  accept;
   logic                  sel_ok;
   logic                  route_beat;
   logic [SEL_W-1:0]      load_chan;

   // ready_en_q holds tready low through reset and the first edge after it.
   assign axis_source_tready = ready_en_q && ((state_q == ST_DROP) || room);
   assign accept             = axis_source_tvalid && axis_source_tready;
   assign sel_ok             = 32'(i_dac_sel) < NUM_DAC;
   assign route_beat         = accept && (((state_q == ST_IDLE) && sel_ok) || (state_q == ST_ROUTE));
   assign load_chan          = (state_q == ST_IDLE) ? i_dac_sel : chan_q;

   always_comb begin
      next_cnt = LEN_W'(1);
      if (state_q == ST_ROUTE) begin
         next_cnt = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         chan_q     <= '0;
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         err_q      <= route_beat && axis_source_tlast && (i_burst_len != '0) &&
                       (next_cnt != i_burst_len);
         if (route_beat) begin
            beat_cnt_q <= next_cnt;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (sel_ok) begin
                     chan_q <= i_dac_sel;
                     if (!axis_source_tlast) state_q <= ST_ROUTE;
                  end else begin
                     drop_cnt_q <= drop_cnt_inc(drop_cnt_q);
                     if (!axis_source_tlast) state_q <= ST_DROP;
                  end
               end
            end
            ST_ROUTE, ST_DROP: begin
               if (accept && axis_source_tlast) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   beam_mux_out_stage #(
      .DATA_W  (DATA_W),
      .NUM_DAC (NUM_DAC)
   ) u_out_stage (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .load       (route_beat),
      .load_data  (axis_source_tdata),
      .load_last  (axis_source_tlast),
      .load_chan  (load_chan),
      .dac_tready (axis_dac_tready),
      .full       (full),
      .room       (room),
      .dac_tdata  (axis_dac_tdata),
      .dac_tvalid (axis_dac_tvalid),
      .dac_tlast  (axis_dac_tlast)
   );

   assign o_burst_size_error = err_q;
   assign o_drop_count       = drop_cnt_q;
   assign o_busy             = (state_q != ST_IDLE) || full;

endmodule

// File: tb/tb_beam_mux_gen2.sv
// Scoreboard bench for beam_mux_gen2 with three DAC channels.
`timescale 1ns/1ps
module tb_beam_mux_gen2;

   localparam int unsigned DW = 32;
   localparam int unsigned ND = 3;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic [DW-1:0]    axis_source_tdata;
   logic             axis_source_tvalid;
   logic             axis_source_tready;
   logic             axis_source_tlast;
   logic [1:0]       i_dac_sel;
   logic [15:0]      i_burst_len;
   logic [ND*DW-1:0] axis_dac_tdata;
   logic [ND-1:0]    axis_dac_tvalid;
   logic [ND-1:0]    axis_dac_tready;
   logic [ND-1:0]    axis_dac_tlast;
   logic             o_burst_size_error;
   logic [15:0]      o_drop_count;
   logic             o_busy;

   beam_mux_gen2 #(
      .DATA_W  (DW),
      .NUM_DAC (ND),
      .LEN_W   (16)
   ) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .axis_source_tdata  (axis_source_tdata),
      .axis_source_tvalid (axis_source_tvalid),
      .axis_source_tready (axis_source_tready),
      .axis_source_tlast  (axis_source_tlast),
      .i_dac_sel          (i_dac_sel),
      .i_burst_len        (i_burst_len),
      .axis_dac_tdata     (axis_dac_tdata),
      .axis_dac_tvalid    (axis_dac_tvalid),
      .axis_dac_tready    (axis_dac_tready),
      .axis_dac_tlast     (axis_dac_tlast),
      .o_burst_size_error (o_burst_size_error),
      .o_drop_count       (o_drop_count),
      .o_busy             (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          chan;
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   err_pulses = 0;
   int   stall_checks = 0;
   bit   chk_stall = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last, input logic [1:0] sel,
                       input int exp_chan);
      int unsigned waited = 0;
      bit ok = 0;
      axis_source_tdata  = d;
      axis_source_tlast  = last;
      i_dac_sel          = sel;
      axis_source_tvalid = 1'b1;
      while (!ok) begin
         @(negedge i_clk);
         ok = axis_source_tready;
         @(posedge i_clk);
         if (!ok) begin
            waited++;
            if (waited > 200) begin
               n_cmp++;
               n_bad++;
               $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
               break;
            end
         end
      end
      if (ok && exp_chan >= 0) sb.push_back('{chan: exp_chan, data: d, last: last});
      #1;
      axis_source_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Monitor: every DAC handshake must match the head of the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_burst_size_error) err_pulses++;
         if (axis_dac_tvalid != '0) check("tvalid_onehot", 64'($countones(axis_dac_tvalid)), 64'd1);
         if (chk_stall && axis_dac_tvalid[0] && !axis_dac_tready[0]) begin
            stall_checks++;
            check("stall_src_tready", 64'(axis_source_tready), 64'd0);
         end
         for (int k = 0; k < int'(ND); k++) begin
            if (axis_dac_tvalid[k] && axis_dac_tready[k]) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: dac%0d data %0h with empty scoreboard",
                           k, axis_dac_tdata[k*DW +: DW]);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("beat_chan", 64'(k), 64'(e.chan));
                  check("beat_data", 64'(axis_dac_tdata[k*DW +: DW]), 64'(e.data));
                  check("beat_last", 64'(axis_dac_tlast[k]), 64'(e.last));
               end
            end
         end
      end
   end

   initial begin
      i_rst_n            = 1'b0;
      axis_source_tdata  = '0;
      axis_source_tvalid = 1'b0;
      axis_source_tlast  = 1'b0;
      i_dac_sel          = '0;
      i_burst_len        = '0;
      axis_dac_tready    = '1;
      repeat (3) @(negedge i_clk);
      check("rst_src_tready", 64'(axis_source_tready), 64'd0);
      check("rst_tvalid", 64'(axis_dac_tvalid), 64'd0);
      check("rst_tlast", 64'(axis_dac_tlast), 64'd0);
      check("rst_drop_count", 64'(o_drop_count), 64'd0);
      check("rst_err", 64'(o_burst_size_error), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      i_rst_n = 1'b1;
      idle(1);

      // 4-beat burst to dac2, length matches
      i_burst_len = 16'd4;
      check("t1_pre_tvalid", 64'(axis_dac_tvalid), 64'd0);
      send(32'hA0, 1'b0, 2'd2, 2);
      check("t1_latency_tvalid", 64'(axis_dac_tvalid), 64'b100);
      send(32'hA1, 1'b0, 2'd2, 2);
      send(32'hA2, 1'b0, 2'd2, 2);
      send(32'hA3, 1'b1, 2'd2, 2);
      idle(3);

      // channel select changes mid-burst are ignored
      i_burst_len = 16'd0;
      send(32'hB10, 1'b0, 2'd1, 1);
      send(32'hB11, 1'b0, 2'd3, 1);
      send(32'hB12, 1'b0, 2'd3, 1);
      send(32'hB13, 1'b1, 2'd3, 1);
      idle(3);

      // out-of-range select: whole burst dropped
      send(32'hD0, 1'b0, 2'd3, -1);
      check("drop_tvalid", 64'(axis_dac_tvalid), 64'd0);
      check("drop_tready", 64'(axis_source_tready), 64'd1);
      send(32'hD1, 1'b0, 2'd0, -1);
      check("drop_tready2", 64'(axis_source_tready), 64'd1);
      send(32'hD2, 1'b0, 2'd0, -1);
      send(32'hD3, 1'b0, 2'd1, -1);
      send(32'hD4, 1'b1, 2'd2, -1);
      check("drop_tvalid_end", 64'(axis_dac_tvalid), 64'd0);
      check("drop_count", 64'(o_drop_count), 64'd1);
      idle(3);

      // 6 beats against expected 8: one-cycle error pulse after tlast
      i_burst_len = 16'd8;
      for (int i = 0; i < 6; i++) send(32'hE0 + 32'(i), (i == 5), 2'd0, 0);
      @(negedge i_clk);
      check("len_err_pulse", 64'(o_burst_size_error), 64'd1);
      @(negedge i_clk);
      check("len_err_width", 64'(o_burst_size_error), 64'd0);
      idle(2);
      i_burst_len = 16'd0;
      for (int i = 0; i < 6; i++) send(32'hF0 + 32'(i), (i == 5), 2'd0, 0);
      @(negedge i_clk);
      check("len_check_off", 64'(o_burst_size_error), 64'd0);
      idle(3);

      // dac0 backpressure 1,0,0,1 during a 4-beat burst
      i_burst_len = 16'd4;
      chk_stall   = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) send(32'hC0 + 32'(i), (i == 3), 2'd0, 0);
         end
         begin
            logic [3:0] pat;
            pat = 4'b1001;
            for (int i = 3; i >= 0; i--) begin
               axis_dac_tready[0] = pat[i];
               @(posedge i_clk);
               #1;
            end
            axis_dac_tready[0] = 1'b1;
         end
      join
      idle(3);
      chk_stall = 1'b0;

      // reset mid-burst after the 2nd beat, then restart on dac2
      i_burst_len = 16'd0;
      send(32'h1B0, 1'b0, 2'd1, 1);
      send(32'h1B1, 1'b0, 2'd1, -1);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      check("mid_rst_tvalid", 64'(axis_dac_tvalid), 64'd0);
      check("mid_rst_tlast", 64'(axis_dac_tlast), 64'd0);
      check("mid_rst_tready", 64'(axis_source_tready), 64'd0);
      check("mid_rst_drop_count", 64'(o_drop_count), 64'd0);
      check("mid_rst_busy", 64'(o_busy), 64'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      idle(1);
      send(32'h2C0, 1'b0, 2'd2, 2);
      check("post_rst_tvalid", 64'(axis_dac_tvalid), 64'b100);
      send(32'h2C1, 1'b1, 2'd2, 2);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge i_clk);
      idle(2);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("err_pulse_total", 64'(err_pulses), 64'd1);
      check("stall_seen", 64'(stall_checks > 0), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
